// File: rtl/pipe_muldiv_ctrl_pkg.sv
// Shared op codes, FSM states and op-decoding helpers for the iterative mul/div sequencer.
package pipe_muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MDS_IDLE = 2'b00,
      MDS_MUL  = 2'b01,
      MDS_DIV  = 2'b10,
      MDS_FIX  = 2'b11
   } md_state_e;

   function automatic logic op_is_div(input md_op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input md_op_e op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/pipe_muldiv_ctrl_md_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring shift-subtract for divide.
module pipe_muldiv_ctrl_md_step
   import pipe_muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  md_op_e             op,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] next_acc
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, dividend/quotient}.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      ge       = (shifted >= {1'b0, operand});
      diff     = shifted[WIDTH-1:0] - operand;
      next_acc = '0;
      if (op_is_div(op))
         next_acc = {(ge ? diff : shifted[WIDTH-1:0]), acc[WIDTH-2:0], ge};
      else
         next_acc = {sum, acc[WIDTH-1:1]};
   end

endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// HI/LO owner and sequencer for the iterative mul/div unit at EXE, including pipeline stall generation.
module pipe_muldiv_ctrl
   import pipe_muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             EXE_md_start,
   input  logic [1:0]       EXE_md_op,
   input  logic [WIDTH-1:0] EXE_a,
   input  logic [WIDTH-1:0] EXE_b,
   input  logic             EXE_mthi,
   input  logic             EXE_mtlo,
   input  logic             EXE_mfhi,
   input  logic             EXE_mflo,
   input  logic             EXE_flush,
   input  logic             md_cancel,
   output logic             md_stall,
   output logic             md_busy,
   output logic [WIDTH-1:0] EXE_hilo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_e          state;
   md_op_e             op;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] step_acc;
   logic [WIDTH-1:0]   operand;
   logic               sign_a;
   logic               sign_b;
   logic               div_zero;

   md_op_e             new_op;
   logic               new_a_neg;
   logic               new_b_neg;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic               b_zero;
   logic               req_start;
   logic               req_mthi;
   logic               req_mtlo;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign md_busy   = (state != MDS_IDLE);
   assign md_stall  = md_busy & (EXE_md_start | EXE_mthi | EXE_mtlo | EXE_mfhi | EXE_mflo) & ~EXE_flush;
   assign req_start = EXE_md_start & ~EXE_flush & ~md_stall;
   assign req_mthi  = EXE_mthi & ~EXE_flush & ~md_stall;
   assign req_mtlo  = EXE_mtlo & ~EXE_flush & ~md_stall;
   assign EXE_hilo  = EXE_mfhi ? hi : lo;

   pipe_muldiv_ctrl_md_step #(.WIDTH(WIDTH)) u_step (
      .op       (op),
      .acc      (acc),
      .operand  (operand),
      .next_acc (step_acc)
   );

   // Operand magnitudes at issue and sign-corrected results at FIX.
   always_comb begin
      new_op    = md_op_e'(EXE_md_op);
      new_a_neg = op_is_signed(new_op) & EXE_a[WIDTH-1];
      new_b_neg = op_is_signed(new_op) & EXE_b[WIDTH-1];
      abs_a     = new_a_neg ? -EXE_a : EXE_a;
      abs_b     = new_b_neg ? -EXE_b : EXE_b;
      b_zero    = (EXE_b == '0);
      product   = (sign_a ^ sign_b) ? -acc : acc;
      quot_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // Cancel wins over everything so an aborted op never touches HI/LO.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= MDS_IDLE;
         op       <= MD_MULT;
         count    <= '0;
         acc      <= '0;
         operand  <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else if (md_cancel) begin
         state <= MDS_IDLE;
         count <= '0;
      end else begin
         case (state)
            MDS_IDLE: begin
               if (req_start) begin
                  op       <= new_op;
                  sign_a   <= new_a_neg;
                  sign_b   <= new_b_neg;
                  count    <= LAST;
                  div_zero <= op_is_div(new_op) & b_zero;
                  if (op_is_div(new_op)) begin
                     operand <= abs_b;
                     acc     <= {{WIDTH{1'b0}}, (b_zero ? EXE_a : abs_a)};
                     state   <= b_zero ? MDS_FIX : MDS_DIV;
                  end else begin
                     operand <= abs_a;
                     acc     <= {{WIDTH{1'b0}}, abs_b};
                     state   <= MDS_MUL;
                  end
               end else if (req_mthi) begin
                  hi <= EXE_a;
               end else if (req_mtlo) begin
                  lo <= EXE_a;
               end
            end
            MDS_MUL, MDS_DIV: begin
               acc <= step_acc;
               if (count == '0)
                  state <= MDS_FIX;
               else
                  count <= count - 1'b1;
            end
            MDS_FIX: begin
               if (!op_is_div(op)) begin
                  hi <= product[2*WIDTH-1:WIDTH];
                  lo <= product[WIDTH-1:0];
               end else if (div_zero) begin
                  hi <= acc[WIDTH-1:0];
                  lo <= {WIDTH{1'b1}};
               end else begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end
               state <= MDS_IDLE;
            end
            default: state <= MDS_IDLE;
         endcase
      end
   end

endmodule
